axilite_s_regbank: RTL and testbench
====================================

AXILITE_S_REGBANK -- requirements
Module: axilite_s_regbank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, byte-address width of awaddr/araddr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, legal values 32 or 64, data bus width.
REQ-003 SHALL have parameter NUM_REGS, default 16, legal range 1..2**(ADDR_WIDTH-log2(DATA_WIDTH/8)), register count.
REQ-004 SHALL have parameter RO_MASK, NUM_REGS bits, default 0; bit i=1 means register i is read-only and sourced from ro_in.
REQ-005 SHALL have parameter RESET_VAL, NUM_REGS*DATA_WIDTH bits, default 0, per-register reset value.
REQ-006 SHALL use one clock; reset is asynchronous and active-high: axi_clk in 1, rising-edge clock; axi_reset in 1, async active-high reset.
REQ-007 SHALL have AW channel ports: awvalid in 1; awready out 1; awaddr in ADDR_WIDTH.
REQ-008 SHALL have W channel ports: wvalid in 1; wready out 1; wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8.
REQ-009 SHALL have B channel ports: bvalid out 1; bready in 1; bresp out 2.
REQ-010 SHALL have AR channel ports: arvalid in 1; arready out 1; araddr in ADDR_WIDTH.
REQ-011 SHALL have R channel ports: rvalid out 1; rready in 1; rdata out DATA_WIDTH; rresp out 2.
REQ-012 SHALL have user ports: reg_out out NUM_REGS*DATA_WIDTH, register i at slice i; reg_wr_pulse out NUM_REGS, one-cycle write strobe; ro_in in NUM_REGS*DATA_WIDTH, read-only sources.

Function
REQ-013 SHALL decode index = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)] and ignore the low byte-offset bits.
REQ-014 SHALL run a write FSM with states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
REQ-015 SHALL assert awready in W_IDLE and W_HAVE_W only, and wready in W_IDLE and W_HAVE_AW only; AW and W SHALL be accepted in either order or in the same cycle.
REQ-016 SHALL latch awaddr, wdata and wstrb on their handshakes and hold them until the write commits.
REQ-017 SHALL commit the write on the clock edge completing the later of the AW/W handshakes, and SHALL set bvalid=1 and enter W_RESP on that same edge.
REQ-018 SHALL, on commit with index<NUM_REGS and RO_MASK[index]=0: update only byte lanes with wstrb=1, pulse reg_wr_pulse[index] high for exactly one cycle (the first bvalid cycle, also when wstrb=0), and set bresp=2'b00.
REQ-019 SHALL, on commit with index>=NUM_REGS or RO_MASK[index]=1: leave all registers unchanged, pulse nothing, and set bresp=2'b10 (SLVERR).
REQ-020 SHALL hold bvalid and bresp stable in W_RESP until bready=1, then return to W_IDLE; awready and wready SHALL stay 0 while in W_RESP.
REQ-021 SHALL run a read FSM with states R_IDLE (arready=1) and R_DATA (rvalid=1).
REQ-022 SHALL, on an AR handshake, register rdata on the same edge (one-cycle latency): ro_in slice with rresp=00 if RO; register value with rresp=00 if RW; 0 with rresp=10 if out of range.
REQ-023 SHALL hold rvalid, rdata and rresp stable until rready=1, then return to R_IDLE; arready SHALL be 0 while rvalid=1.
REQ-024 SHALL return the pre-write value when a read of register i is captured on the same edge as a write commit to register i.
REQ-025 SHALL operate the read and write FSMs independently and concurrently.
REQ-026 SHALL drive reg_out continuously from register storage; RO register slices of reg_out SHALL hold RESET_VAL permanently.

Reset
REQ-027 SHALL, while axi_reset=1, force awready=wready=arready=bvalid=rvalid=0, bresp=rresp=0, rdata=0, reg_wr_pulse=0, FSMs to W_IDLE/R_IDLE, and registers to RESET_VAL.
REQ-028 SHALL, on reset asserted mid-transaction, abort it asynchronously: no commit, no pending response after release.
REQ-029 SHALL assert awready, wready and arready in the first cycle after reset deasserts.

Verification
REQ-030 SHALL cover AW then W 3 cycles later, addr 0x008, wdata 0xA5A5_1234, wstrb 4'b0011 (reg2 reset 0) -> bvalid the cycle after the W handshake, bresp 00, reg2=0x0000_1234, reg_wr_pulse[2] high one cycle.
REQ-031 SHALL cover W before AW and same-cycle AW+W to reg5 with bready held low 4 cycles -> bvalid held 4 cycles, no second AW/W accepted, single commit.
REQ-032 SHALL cover a write to addr 0x040 with NUM_REGS=16, and a write to an RO_MASK register -> bresp 10, no register change, no pulse.
REQ-033 SHALL cover a read of reg2 after REQ-030, and a read of 0x040 -> rdata 0x0000_1234 rresp 00; rdata 0 rresp 10; rvalid held under rready=0.
REQ-034 SHALL cover a same-edge read and write commit to reg7 (old 0x11, new 0x22) -> rdata 0x11, then a subsequent read returns 0x22.
REQ-035 SHALL cover axi_reset pulsed between the AW and W handshakes -> no bvalid after release, reg unchanged at RESET_VAL, readies 1 in the next cycle.

Source files
------------

// File: rtl/axilite_s_regbank_if.sv
// AXI4-Lite bus bundle for the register bank: AW/W/B/AR/R channels.
// The master modport drives requests, and the slave modport drives ready and response signals.
interface axilite_s_regbank_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axilite_s_regbank.sv
// AXI4-Lite slave register bank with independent read and write FSMs.
// It supports per-register read-only masking, per-register reset values, and one-cycle write strobes.
module axilite_s_regbank #(
  parameter int                               ADDR_WIDTH = 12,
  parameter int                               DATA_WIDTH = 32,
  parameter int                               NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]              RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VAL  = '0
) (
  input  logic                               axi_clk,
  input  logic                               axi_reset,
  axilite_s_regbank_if.slave                 s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0]     reg_out,
  output logic [NUM_REGS-1:0]                reg_wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]     ro_in
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = ADDR_WIDTH - ADDR_LSB;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}                      rd_state_t;

  wr_state_t               r_wr_state;
  rd_state_t               r_rd_state;
  logic [IDX_WIDTH-1:0]    r_aw_idx;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_WIDTH-1:0]   r_wstrb;
  logic                    r_bvalid;
  logic [1:0]              r_bresp;
  logic                    r_rvalid;
  logic [1:0]              r_rresp;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [NUM_REGS-1:0]     r_wr_pulse;
  logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];

  logic [IDX_WIDTH-1:0]    w_aw_idx;
  logic [IDX_WIDTH-1:0]    w_ar_idx;
  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_ar_hs;
  logic                    w_commit;
  logic                    w_cmt_ok;
  logic [IDX_WIDTH-1:0]    w_cmt_idx;
  logic [DATA_WIDTH-1:0]   w_cmt_data;
  logic [STRB_WIDTH-1:0]   w_cmt_strb;
  logic                    w_rd_hit;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  logic                    w_unused_lsbs;

  assign w_aw_idx      = s_axi.awaddr[ADDR_WIDTH-1:ADDR_LSB];
  assign w_ar_idx      = s_axi.araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign w_unused_lsbs = ^{s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};

  // The readies decode from the state register, so they rise as soon as reset releases.
  assign s_axi.awready = !axi_reset && (r_wr_state == W_IDLE || r_wr_state == W_HAVE_W);
  assign s_axi.wready  = !axi_reset && (r_wr_state == W_IDLE || r_wr_state == W_HAVE_AW);
  assign s_axi.arready = !axi_reset && (r_rd_state == R_IDLE);

  assign w_aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_w_hs  = s_axi.wvalid  && s_axi.wready;
  assign w_ar_hs = s_axi.arvalid && s_axi.arready;

  // The commit takes the live value on the channel completing now, and the latched value on the other channel.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    w_commit   = 1'b0;
    w_cmt_idx  = r_aw_idx;
    w_cmt_data = r_wdata;
    w_cmt_strb = r_wstrb;
    case (r_wr_state)
      W_IDLE: begin
        w_commit   = w_aw_hs && w_w_hs;
        w_cmt_idx  = w_aw_idx;
        w_cmt_data = s_axi.wdata;
        w_cmt_strb = s_axi.wstrb;
      end
      W_HAVE_AW: begin
        w_commit   = w_w_hs;
        w_cmt_data = s_axi.wdata;
        w_cmt_strb = s_axi.wstrb;
      end
      W_HAVE_W: begin
        w_commit   = w_aw_hs;
        w_cmt_idx  = w_aw_idx;
      end
      default: ;
    endcase

    w_cmt_ok = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_cmt_idx == IDX_WIDTH'(i) && !RO_MASK[i]) w_cmt_ok = 1'b1;
    end
  end

  always_comb begin
    w_rd_hit  = 1'b0;
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == IDX_WIDTH'(i)) begin
        w_rd_hit  = 1'b1;
        w_rd_data = RO_MASK[i] ? ro_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
      end
    end
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_wr_state <= W_IDLE;
      r_aw_idx   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
    end else begin
      // NOTE: state updates use non-blocking assignment so every reader sees pre-edge values.
      if (w_aw_hs) r_aw_idx <= w_aw_idx;
      if (w_w_hs) begin
        r_wdata <= s_axi.wdata;
        r_wstrb <= s_axi.wstrb;
      end
      if (w_commit) begin
        r_wr_state <= W_RESP;
        r_bvalid   <= 1'b1;
        r_bresp    <= w_cmt_ok ? 2'b00 : 2'b10;
      end else begin
        case (r_wr_state)
          W_IDLE: begin
            if (w_aw_hs)     r_wr_state <= W_HAVE_AW;
            else if (w_w_hs) r_wr_state <= W_HAVE_W;
          end
          W_RESP: begin
            if (s_axi.bready) begin
              r_wr_state <= W_IDLE;
              r_bvalid   <= 1'b0;
              r_bresp    <= 2'b00;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_wr_pulse <= '0;
      // NOTE: the register array is reset element by element because each entry has its own reset value.
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      r_wr_pulse <= '0;
      if (w_commit && w_cmt_ok) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (!RO_MASK[i] && w_cmt_idx == IDX_WIDTH'(i)) begin
            r_wr_pulse[i] <= 1'b1;
            for (int b = 0; b < STRB_WIDTH; b++) begin
              if (w_cmt_strb[b]) r_regs[i][b*8 +: 8] <= w_cmt_data[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // The read path samples r_regs before a same-edge write lands, so it returns the old value.
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_rd_state <= R_IDLE;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= 2'b00;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rd_state <= R_DATA;
            r_rvalid   <= 1'b1;
            r_rdata    <= w_rd_data;
            r_rresp    <= w_rd_hit ? 2'b00 : 2'b10;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            r_rd_state <= R_IDLE;
            r_rvalid   <= 1'b0;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  assign s_axi.bvalid = r_bvalid;
  assign s_axi.bresp  = r_bresp;
  assign s_axi.rvalid = r_rvalid;
  assign s_axi.rdata  = r_rdata;
  assign s_axi.rresp  = r_rresp;
  assign reg_wr_pulse = r_wr_pulse;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

endmodule

// File: tb/tb_axilite_s_regbank.sv
// Directed bench for axilite_s_regbank: a register model plus B and R response scoreboards.
// Reg3 is read-only and reg9 has a non-zero reset value.
module tb_axilite_s_regbank;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam logic [NR-1:0]    RO = 16'h0008;
  localparam logic [NR*DW-1:0] RV = (512'(32'hCAFE_0009) << (9*DW)) |
                                    (512'(32'h0303_0303) << (3*DW));

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rsp_t;

  logic              axi_clk = 1'b0;
  logic              axi_reset;
  logic [NR*DW-1:0]  reg_out;
  logic [NR-1:0]     reg_wr_pulse;
  logic [NR*DW-1:0]  ro_in;

  logic [DW-1:0]     m_regs [NR];
  rsp_t              b_q [$];
  rsp_t              r_q [$];
  int                n_checks = 0;
  int                n_fail   = 0;

  axilite_s_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axilite_s_regbank #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .RO_MASK    (RO),
    .RESET_VAL  (RV)
  ) dut (
    .axi_clk      (axi_clk),
    .axi_reset    (axi_reset),
    .s_axi        (bus),
    .reg_out      (reg_out),
    .reg_wr_pulse (reg_wr_pulse),
    .ro_in        (ro_in)
  );

  always #5 axi_clk = ~axi_clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  function automatic logic [NR*DW-1:0] pack_model();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_regs[i];
    return v;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                          input logic [DW/8-1:0] strb);
    logic [DW-1:0] v;
    v = old_v;
    for (int b = 0; b < DW/8; b++) if (strb[b]) v[b*8 +: 8] = new_v[b*8 +: 8];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = RV[i*DW +: DW];
  endtask

  task automatic send_aw(input string tag, input logic [AW-1:0] a);
    int n = 0;
    bus.awvalid = 1'b1;
    bus.awaddr  = a;
    while (!bus.awready && n < 20) begin tick(); n++; end
    check({tag, "_awready"}, bus.awready, 1'b1);
    tick();
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input string tag, input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    int n = 0;
    bus.wvalid = 1'b1;
    bus.wdata  = d;
    bus.wstrb  = s;
    while (!bus.wready && n < 20) begin tick(); n++; end
    check({tag, "_wready"}, bus.wready, 1'b1);
    tick();
    bus.wvalid = 1'b0;
  endtask

  task automatic send_aw_w(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW/8-1:0] s);
    int n = 0;
    bus.awvalid = 1'b1;
    bus.awaddr  = a;
    bus.wvalid  = 1'b1;
    bus.wdata   = d;
    bus.wstrb   = s;
    while (!(bus.awready && bus.wready) && n < 20) begin tick(); n++; end
    check({tag, "_both_ready"}, {bus.awready, bus.wready}, 2'b11);
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
  endtask

  // order: 0 = AW first, 1 = W first, 2 = same cycle; gap is the idle cycles between the two channels.
  task automatic write_txn(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW/8-1:0] s, input int order, input int gap);
    int   idx;
    logic ok;
    idx = int'(a[AW-1:2]);
    ok  = (idx < NR) ? !RO[idx] : 1'b0;
    b_q.push_back('{data: '0, resp: ok ? 2'b00 : 2'b10});
    case (order)
      0: begin
        send_aw(tag, a);
        check({tag, "_mid_readies"}, {bus.awready, bus.wready}, 2'b01);
        repeat (gap) tick();
        send_w(tag, d, s);
      end
      1: begin
        send_w(tag, d, s);
        check({tag, "_mid_readies"}, {bus.awready, bus.wready}, 2'b10);
        repeat (gap) tick();
        send_aw(tag, a);
      end
      default: send_aw_w(tag, a, d, s);
    endcase
    if (ok) m_regs[idx] = merge(m_regs[idx], d, s);
    check({tag, "_bvalid"}, bus.bvalid, 1'b1);
    check({tag, "_pulse"}, reg_wr_pulse, ok ? (NR'(1) << idx) : NR'(0));
    check({tag, "_reg_out"}, reg_out, pack_model());
  endtask

  task automatic collect_b(input string tag, input int hold);
    rsp_t e;
    int   n = 0;
    while (!bus.bvalid && n < 20) begin tick(); n++; end
    check({tag, "_b_seen"}, bus.bvalid, 1'b1);
    if (b_q.size() == 0) begin
      check({tag, "_b_q_nonempty"}, 1'b0, 1'b1);
      return;
    end
    e = b_q.pop_front();
    check({tag, "_bresp"}, bus.bresp, e.resp);
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, "_b_hold"}, {bus.bvalid, bus.bresp, bus.awready, bus.wready}, {1'b1, e.resp, 2'b00});
      check({tag, "_b_hold_pulse"}, reg_wr_pulse, NR'(0));
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check({tag, "_b_done"}, {bus.bvalid, reg_wr_pulse}, {1'b0, NR'(0)});
  endtask

  task automatic collect_r(input string tag, input int hold);
    rsp_t e;
    int   n = 0;
    while (!bus.rvalid && n < 20) begin tick(); n++; end
    check({tag, "_r_seen"}, bus.rvalid, 1'b1);
    if (r_q.size() == 0) begin
      check({tag, "_r_q_nonempty"}, 1'b0, 1'b1);
      return;
    end
    e = r_q.pop_front();
    check({tag, "_rdata"}, bus.rdata, e.data);
    check({tag, "_rresp"}, bus.rresp, e.resp);
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, "_r_hold"}, {bus.rvalid, bus.arready, bus.rresp, bus.rdata}, {2'b10, e.resp, e.data});
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    check({tag, "_r_done"}, {bus.rvalid, bus.arready}, 2'b01);
  endtask

  task automatic read_txn(input string tag, input logic [AW-1:0] a, input int hold);
    int   idx;
    int   n = 0;
    rsp_t e;
    idx = int'(a[AW-1:2]);
    if (idx >= NR)   e = '{data: '0, resp: 2'b10};
    else if (RO[idx]) e = '{data: ro_in[idx*DW +: DW], resp: 2'b00};
    else             e = '{data: m_regs[idx], resp: 2'b00};
    r_q.push_back(e);
    bus.arvalid = 1'b1;
    bus.araddr  = a;
    while (!bus.arready && n < 20) begin tick(); n++; end
    check({tag, "_arready"}, bus.arready, 1'b1);
    tick();
    bus.arvalid = 1'b0;
    collect_r(tag, hold);
  endtask

  initial begin
    axi_reset   = 1'b1;
    bus.awvalid = 1'b0;
    bus.awaddr  = '0;
    bus.wvalid  = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0;
    bus.araddr  = '0;
    bus.rready  = 1'b0;
    for (int i = 0; i < NR; i++) ro_in[i*DW +: DW] = 32'hB0B0_0000 | 32'(i);
    ro_in[3*DW +: DW] = 32'h1357_9BDF;
    model_reset();

    // Reset state
    repeat (2) @(posedge axi_clk);
    #1;
    check("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
    check("rst_valids", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}, 6'b0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_pulse", reg_wr_pulse, NR'(0));
    check("rst_reg_out", reg_out, RV);
    axi_reset = 1'b0;
    #1;
    check("post_rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
    tick();

    // Partial-strobe write, with AW arriving before W
    write_txn("aw_then_w", 12'h008, 32'hA5A5_1234, 4'b0011, 0, 2);
    collect_b("aw_then_w", 0);

    // W arrives before AW, then the response is stalled while new requests are pending
    write_txn("w_then_aw", 12'h014, 32'h5555_AAAA, 4'hF, 1, 1);
    bus.awvalid = 1'b1;
    bus.awaddr  = 12'h014;
    bus.wvalid  = 1'b1;
    bus.wdata   = 32'hDEAD_BEEF;
    bus.wstrb   = 4'hF;
    collect_b("b_stall", 3);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("single_commit", reg_out, pack_model());
    write_txn("same_cycle", 12'h014, 32'h1234_5678, 4'b1100, 2, 0);
    collect_b("same_cycle", 0);

    // Error responses: an out-of-range address and a read-only register
    write_txn("wr_oor", 12'h040, 32'hFFFF_FFFF, 4'hF, 2, 0);
    collect_b("wr_oor", 0);
    write_txn("wr_ro", 12'h00C, 32'hFFFF_FFFF, 4'hF, 0, 0);
    collect_b("wr_ro", 0);

    // Reads: a stalled RW read, an out-of-range read, an RO read, and a read with byte-offset bits set
    read_txn("rd_reg2", 12'h008, 3);
    read_txn("rd_oor", 12'h040, 1);
    read_txn("rd_ro", 12'h00C, 0);
    read_txn("rd_reg9_off", 12'h026, 0);

    // Read and write commit land on the same edge for reg7
    write_txn("w7_init", 12'h01C, 32'h0000_0011, 4'hF, 2, 0);
    collect_b("w7_init", 0);
    r_q.push_back('{data: m_regs[7], resp: 2'b00});
    b_q.push_back('{data: '0, resp: 2'b00});
    bus.arvalid = 1'b1;
    bus.araddr  = 12'h01C;
    bus.awvalid = 1'b1;
    bus.awaddr  = 12'h01C;
    bus.wvalid  = 1'b1;
    bus.wdata   = 32'h0000_0022;
    bus.wstrb   = 4'hF;
    check("coll_readies", {bus.arready, bus.awready, bus.wready}, 3'b111);
    tick();
    bus.arvalid = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    m_regs[7] = 32'h0000_0022;
    check("coll_both_valid", {bus.bvalid, bus.rvalid}, 2'b11);
    collect_b("coll", 0);
    collect_r("coll", 0);
    read_txn("rd_reg7_new", 12'h01C, 0);

    // Reset pulse between the AW and W handshakes
    send_aw("rst_mid", 12'h024);
    axi_reset = 1'b1;
    #1;
    check("rst_mid_forced", {bus.awready, bus.wready, bus.arready, bus.bvalid}, 4'b0000);
    check("rst_mid_reg_out", reg_out, RV);
    #2;
    axi_reset = 1'b0;
    #1;
    check("rst_mid_release", {bus.awready, bus.wready, bus.arready}, 3'b111);
    model_reset();
    send_w("rst_mid", 32'hFFFF_FFFF, 4'hF);
    check("rst_mid_w_only", {bus.awready, bus.wready, bus.bvalid}, 3'b100);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_mid_no_b", {bus.bvalid, reg_wr_pulse}, {1'b0, NR'(0)});
    end
    check("rst_mid_regs", reg_out, pack_model());

    check("b_q_drained", b_q.size(), 0);
    check("r_q_drained", r_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
